risc_mem_arbiter: RTL and testbench

Two-port arbiter sharing the RISC core's single 32x8 program/data memory between the CPU datapath and a debug/loader port. It sits between the core's memory-access logic and `memory_inst`, and serializes accesses at up to one per clock. When the core halts, debug traffic has absolute priority. While the core runs, debug traffic has starvation-bounded access, so memory can be inspected or patched without stopping the core.

---
 rtl/risc_pkg.sv | 36 +++
 rtl/risc_arb_starve_ctr.sv | 38 +++
 rtl/risc_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_risc_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// risc_pkg
//   Shared definitions for the RISC core memory subsystem.
//   - DEF_AWIDTH / DEF_DWIDTH : default memory geometry (32 x 8)
//   - WAIT_W                  : width of the debug starvation counter
//   - arb_state_e             : memory arbiter state encoding
//   - HLT..JMP                : core opcode constants
//   - sat_inc                 : saturating increment helper
package risc_pkg;

  localparam int DEF_AWIDTH = 5;
  localparam int DEF_DWIDTH = 8;
  localparam int WAIT_W     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DBG_ACC = 2'd2
  } arb_state_e;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  function automatic logic [WAIT_W-1:0] sat_inc(
    input logic [WAIT_W-1:0] val,
    input logic [WAIT_W-1:0] lim
  );
    return (val >= lim) ? lim : val + WAIT_W'(1);
  endfunction

endpackage

// File: rtl/risc_arb_starve_ctr.sv
// risc_arb_starve_ctr
//   Counts consecutive arbitration edges at which a pending debug request
//   lost to the CPU. Saturates at MAX_WAIT; starve flags the saturated value.
//   Ports:
//     clk      in  : clock, rising edge
//     rst      in  : asynchronous active-low reset
//     dbg_req  in  : debug request (live)
//     dbg_win  in  : debug wins arbitration at this edge
//     starve   out : wait count has reached MAX_WAIT
module risc_arb_starve_ctr
  import risc_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_req,
  input  logic dbg_win,
  output logic starve
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!dbg_req || dbg_win) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= sat_inc(wait_cnt, WAIT_LIM);
    end
  end

  assign starve = (wait_cnt == WAIT_LIM);

endmodule

// File: rtl/risc_mem_arbiter.sv
// risc_mem_arbiter
//   Serializes CPU and debug/loader accesses onto the single program/data
//   memory, one access per clock. Debug has absolute priority while the core
//   is halted; while running, debug wins once it has been stalled MAX_WAIT
//   consecutive edges.
//   Ports:
//     clk, rst                     : clock, asynchronous active-low reset
//     halt                         : core halted flag
//     cpu_req/we/addr/wdata        : CPU command (hold until cpu_gnt)
//     cpu_gnt                      : CPU access executing this cycle
//     cpu_rdata/cpu_valid          : registered CPU read data + 1-cycle pulse
//     dbg_*                        : same as cpu_* for the debug port
//     mem_rd/mem_wr/addr/wdata     : memory strobes and command
//     mem_rdata                    : memory read data, same cycle as mem_rd
//
//   state   | meaning
//   --------+---------------------------------
//   IDLE    | no access
//   CPU_ACC | CPU access executing
//   DBG_ACC | debug access executing
module risc_mem_arbiter
  import risc_pkg::*;
#(
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_valid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [AWIDTH-1:0] dbg_addr,
  input  logic [DWIDTH-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DWIDTH-1:0] dbg_rdata,
  output logic              dbg_valid,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic              cpu_win;
  logic              dbg_win;
  logic              starve;
  logic              busy;
  logic              cmd_we;
  logic [AWIDTH-1:0] cmd_addr;
  logic [DWIDTH-1:0] cmd_wdata;

  risc_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk     (clk),
    .rst     (rst),
    .dbg_req (dbg_req),
    .dbg_win (dbg_win),
    .starve  (starve)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: arbitration happens at every edge regardless of the current
  // state, so a requester presenting its next command during gnt gets
  // back-to-back service. A lone debug request wins even while running.
  always_comb begin
    dbg_win   = 1'b0;
    cpu_win   = 1'b0;
    state_nxt = IDLE;
    if (dbg_req && (halt || starve || !cpu_req)) begin
      dbg_win   = 1'b1;
      state_nxt = DBG_ACC;
    end else if (cpu_req) begin
      cpu_win   = 1'b1;
      state_nxt = CPU_ACC;
    end
  end

  // Outputs
  always_comb begin
    busy      = (state != IDLE);
    cpu_gnt   = (state == CPU_ACC);
    dbg_gnt   = (state == DBG_ACC);
    mem_wr    = busy && cmd_we;
    mem_rd    = busy && !cmd_we;
    mem_addr  = busy ? cmd_addr  : '0;
    mem_wdata = busy ? cmd_wdata : '0;
  end

  // Command register: winner's command is captured at the arbitration edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (dbg_win) begin
      cmd_we    <= dbg_we;
      cmd_addr  <= dbg_addr;
      cmd_wdata <= dbg_wdata;
    end else if (cpu_win) begin
      cmd_we    <= cpu_we;
      cmd_addr  <= cpu_addr;
      cmd_wdata <= cpu_wdata;
    end
  end

  // Read completion: capture at the edge that ends the read's gnt cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata <= '0;
      cpu_valid <= 1'b0;
      dbg_rdata <= '0;
      dbg_valid <= 1'b0;
    end else begin
      cpu_valid <= (state == CPU_ACC) && !cmd_we;
      dbg_valid <= (state == DBG_ACC) && !cmd_we;
      if ((state == CPU_ACC) && !cmd_we) begin
        cpu_rdata <= mem_rdata;
      end
      if ((state == DBG_ACC) && !cmd_we) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_risc_mem_arbiter.sv
module tb_risc_mem_arbiter;

  logic       clk;
  logic       rst;
  logic       halt;
  logic       cpu_req, cpu_we;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_gnt, cpu_valid;
  logic [7:0] cpu_rdata;
  logic       dbg_req, dbg_we;
  logic [4:0] dbg_addr;
  logic [7:0] dbg_wdata;
  logic       dbg_gnt, dbg_valid;
  logic [7:0] dbg_rdata;
  logic       mem_rd, mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0] cpu_q[$];
  logic [7:0] dbg_q[$];
  logic [7:0] ref_mem [32];

  // Memory model: combinational read, write at the edge ending the strobe.
  logic [7:0]  mem [32];
  logic [31:0] wr_mask = '0;

  function automatic logic [7:0] init_val(input logic [4:0] a);
    return (a == 5'd5) ? 8'h01 : 8'h10 + {3'b000, a};
  endfunction

  assign mem_rdata = mem_rd ? (wr_mask[mem_addr] ? mem[mem_addr] : init_val(mem_addr)) : 8'h00;

  always @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_addr]     <= mem_wdata;
      wr_mask[mem_addr] <= 1'b1;
    end
  end

  risc_mem_arbiter #(
    .AWIDTH   (5),
    .DWIDTH   (8),
    .MAX_WAIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .halt      (halt),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rdata (cpu_rdata),
    .cpu_valid (cpu_valid),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rdata (dbg_rdata),
    .dbg_valid (dbg_valid),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [63:0] all_outs();
    return {29'd0, cpu_gnt, dbg_gnt, cpu_valid, dbg_valid, mem_rd, mem_wr,
            mem_addr, mem_wdata, cpu_rdata, dbg_rdata};
  endfunction

  // Scoreboard: every valid pulse pops the oldest expected read for its port.
  always @(negedge clk) begin
    if (cpu_valid) begin
      if (cpu_q.size() == 0) check("cpu_valid_unexpected", 64'(cpu_valid), 64'd0);
      else check("cpu_rdata_sb", 64'(cpu_rdata), 64'(cpu_q.pop_front()));
    end
    if (dbg_valid) begin
      if (dbg_q.size() == 0) check("dbg_valid_unexpected", 64'(dbg_valid), 64'd0);
      else check("dbg_rdata_sb", 64'(dbg_rdata), 64'(dbg_q.pop_front()));
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(5'(i));
    rst = 1'b0; halt = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd3; cpu_wdata = 8'h00;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 8'h00;

    // Reset held with a CPU request pending
    repeat (3) cyc();
    check("reset_outputs", all_outs(), 64'd0);
    rst = 1'b1;
    cpu_q.push_back(ref_mem[3]);
    cyc();
    check("rel_cpu_gnt", 64'(cpu_gnt), 64'd1);
    check("rel_mem_rd", 64'(mem_rd), 64'd1);
    check("rel_mem_addr", 64'(mem_addr), 64'd3);
    cpu_req = 1'b0;
    cyc();
    check("rel_gnt_drop", 64'(cpu_gnt), 64'd0);
    check("rel_cpu_valid", 64'(cpu_valid), 64'd1);

    // CPU read of addr 5
    cpu_req = 1'b1; cpu_addr = 5'd5;
    cpu_q.push_back(ref_mem[5]);
    cyc();
    check("rd5_gnt", 64'(cpu_gnt), 64'd1);
    check("rd5_mem_rd", 64'(mem_rd), 64'd1);
    check("rd5_mem_wr", 64'(mem_wr), 64'd0);
    check("rd5_mem_addr", 64'(mem_addr), 64'd5);
    cpu_req = 1'b0;
    cyc();
    check("rd5_valid", 64'(cpu_valid), 64'd1);
    check("rd5_rdata", 64'(cpu_rdata), 64'h01);

    // Halted: debug wins every contested edge
    halt = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd2;
    cpu_q.push_back(ref_mem[2]);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd8; dbg_wdata = 8'hA5;
    ref_mem[8] = 8'hA5;
    cyc();
    check("halt_wr_dbg_gnt", 64'(dbg_gnt), 64'd1);
    check("halt_wr_cpu_gnt", 64'(cpu_gnt), 64'd0);
    check("halt_wr_mem_wr", 64'(mem_wr), 64'd1);
    check("halt_wr_mem_addr", 64'(mem_addr), 64'd8);
    check("halt_wr_mem_wdata", 64'(mem_wdata), 64'hA5);
    dbg_we = 1'b0;
    dbg_q.push_back(ref_mem[8]);
    cyc();
    check("halt_rd_dbg_gnt", 64'(dbg_gnt), 64'd1);
    check("halt_rd_cpu_gnt", 64'(cpu_gnt), 64'd0);
    check("halt_rd_mem_rd", 64'(mem_rd), 64'd1);
    dbg_req = 1'b0;
    cyc();
    check("halt_cpu_after", 64'(cpu_gnt), 64'd1);
    check("halt_dbg_valid", 64'(dbg_valid), 64'd1);
    check("halt_dbg_rdata", 64'(dbg_rdata), 64'hA5);
    cpu_req = 1'b0; halt = 1'b0;
    cyc();
    check("halt_cpu_valid", 64'(cpu_valid), 64'd1);
    check("halt_idle_gnt", 64'(cpu_gnt), 64'd0);

    // CPU write then debug read of the same address
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd9; cpu_wdata = 8'h3C;
    ref_mem[9] = 8'h3C;
    cyc();
    check("ord_cpu_gnt", 64'(cpu_gnt), 64'd1);
    check("ord_mem_wdata", 64'(mem_wdata), 64'h3C);
    cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9;
    dbg_q.push_back(ref_mem[9]);
    cyc();
    check("ord_dbg_gnt", 64'(dbg_gnt), 64'd1);
    check("ord_mem_rd", 64'(mem_rd), 64'd1);
    dbg_req = 1'b0;
    cyc();
    check("ord_dbg_valid", 64'(dbg_valid), 64'd1);

    // Starvation bound: debug granted on the 5th grant cycle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd20; cpu_wdata = 8'h5A;
    ref_mem[20] = 8'h5A;
    cyc();
    check("stv_pre_cpu_gnt", 64'(cpu_gnt), 64'd1);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd20;
    dbg_q.push_back(ref_mem[20]);
    for (int g = 1; g <= 5; g++) begin
      cyc();
      check($sformatf("stv_cpu_gnt_%0d", g), 64'(cpu_gnt), (g < 5) ? 64'd1 : 64'd0);
      check($sformatf("stv_dbg_gnt_%0d", g), 64'(dbg_gnt), (g == 5) ? 64'd1 : 64'd0);
    end
    dbg_req = 1'b0;
    cyc();
    check("stv_cpu_resume", 64'(cpu_gnt), 64'd1);
    check("stv_dbg_valid", 64'(dbg_valid), 64'd1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    cyc();
    check("stv_idle_wr", 64'(mem_wr), 64'd0);

    // Back-to-back CPU reads of 0, 1, 2
    cpu_req = 1'b1; cpu_addr = 5'd0;
    cpu_q.push_back(ref_mem[0]);
    for (int a = 0; a < 3; a++) begin
      cyc();
      check($sformatf("b2b_gnt_%0d", a), 64'(cpu_gnt), 64'd1);
      check($sformatf("b2b_addr_%0d", a), 64'(mem_addr), 64'(a));
      check($sformatf("b2b_valid_%0d", a), 64'(cpu_valid), (a > 0) ? 64'd1 : 64'd0);
      if (a < 2) begin
        cpu_addr = 5'(a + 1);
        cpu_q.push_back(ref_mem[a + 1]);
      end else begin
        cpu_req = 1'b0;
      end
    end
    cyc();
    check("b2b_last_valid", 64'(cpu_valid), 64'd1);
    check("b2b_last_rdata", 64'(cpu_rdata), 64'(ref_mem[2]));
    check("b2b_gnt_done", 64'(cpu_gnt), 64'd0);

    // Reset pulsed during a read's gnt cycle
    cpu_req = 1'b1; cpu_addr = 5'd4;
    cyc();
    check("rstmid_gnt", 64'(cpu_gnt), 64'd1);
    rst = 1'b0; cpu_req = 1'b0;
    #1;
    check("rstmid_async_outs", all_outs(), 64'd0);
    cyc();
    check("rstmid_held_outs", all_outs(), 64'd0);
    rst = 1'b1;
    cyc();
    check("rstmid_idle", all_outs(), 64'd0);
    cpu_req = 1'b1; cpu_addr = 5'd6;
    cpu_q.push_back(ref_mem[6]);
    cyc();
    check("rstmid_restart_gnt", 64'(cpu_gnt), 64'd1);
    cpu_req = 1'b0;
    cyc();
    check("rstmid_restart_valid", 64'(cpu_valid), 64'd1);
    cyc();
    check("cpu_q_drained", 64'(cpu_q.size()), 64'd0);
    check("dbg_q_drained", 64'(dbg_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
